// File: rtl/color_ctrl_pkg.sv
// Shared constants for the keyboard-driven colour stepper: decoder states,
// channel indices and the PS/2 set-2 prefix bytes.
package color_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_BRK  = 2'd2
    } dec_state_t;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 3;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;

    // Round-robin successor in R, G, B order.
    function automatic logic [1:0] ch_next(input logic [1:0] ch);
        return (ch == CH_B) ? CH_R : ch + 2'd1;
    endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating pending-request counter for one colour channel, with a sticky
// flag recording any increment that was dropped at the limit.
module pend_counter
    import color_ctrl_pkg::*;
#(
    parameter int MAX_PEND = 7
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_PEND);

    // inc and dec together cancel, so a saturated counter being granted
    // absorbs the new request without flagging it.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == LIMIT)
                ovf <= 1'b1;
            else
                count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/color_step_scheduler.sv
// Turns PS/2 make codes into per-channel step requests and releases at most
// one step per frame, round-robin across R, G, B.
module color_step_scheduler
    import color_ctrl_pkg::*;
#(
    parameter int         MAX_PEND = 7,
    parameter logic [7:0] CODE_R   = 8'h2D,
    parameter logic [7:0] CODE_G   = 8'h34,
    parameter logic [7:0] CODE_B   = 8'h32
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       frame_start,
    output logic       r_step,
    output logic       g_step,
    output logic       b_step,
    output logic       pending_any,
    output logic       overflow
);

    dec_state_t state, state_nxt;
    logic       make_key;

    logic [NUM_CH-1:0][7:0]       ch_code;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0]            nz;
    logic [NUM_CH-1:0]            inc;
    logic [NUM_CH-1:0]            grant;
    logic [NUM_CH-1:0]            ovf;
    logic [NUM_CH-1:0]            step_q;
    logic [1:0]                   ptr, ptr_nxt;

    assign ch_code = {CODE_B, CODE_G, CODE_R};

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        make_key  = 1'b0;
        if (key_valid) begin
            case (state)
                ST_IDLE: begin
                    if (key_code == PFX_EXT)
                        state_nxt = ST_EXT;
                    else if (key_code == PFX_BRK)
                        state_nxt = ST_BRK;
                    else
                        make_key = 1'b1;
                end
                ST_EXT:  state_nxt = (key_code == PFX_BRK) ? ST_BRK : ST_IDLE;
                ST_BRK:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign inc[i] = make_key && (key_code == ch_code[i]);
        assign nz[i]  = (cnt[i] != '0);

        pend_counter #(.MAX_PEND(MAX_PEND)) u_cnt (
            .vga_clk (vga_clk),
            .reset   (reset),
            .inc     (inc[i]),
            .dec     (grant[i]),
            .count   (cnt[i]),
            .ovf     (ovf[i])
        );
    end

    // Walk the channels starting at ptr; first non-empty one wins.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        grant   = '0;
        ptr_nxt = ptr;
        idx     = ptr;
        found   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (frame_start && !found && nz[idx]) begin
                grant[idx] = 1'b1;
                ptr_nxt    = ch_next(idx);
                found      = 1'b1;
            end
            idx = ch_next(idx);
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            ptr    <= CH_R;
            step_q <= '0;
        end else begin
            ptr    <= ptr_nxt;
            step_q <= grant;
        end
    end

    assign r_step      = step_q[CH_R];
    assign g_step      = step_q[CH_G];
    assign b_step      = step_q[CH_B];
    assign pending_any = |nz;
    assign overflow    = |ovf;

endmodule

// File: tb/tb_color_step_scheduler.sv
// Directed bench: each frame_start pushes the expected {r,g,b} step vector,
// and a monitor compares it on the cycle the DUT presents the step.
module tb_color_step_scheduler;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code  = 8'h00;
    logic       frame_start = 1'b0;
    logic       r_step, g_step, b_step, pending_any, overflow;

    int n_chk  = 0;
    int n_pass = 0;
    logic [2:0] exp_q[$];
    logic       fs_seen = 1'b0;

    always #5 vga_clk = ~vga_clk;

    color_step_scheduler dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .frame_start (frame_start),
        .r_step      (r_step),
        .g_step      (g_step),
        .b_step      (b_step),
        .pending_any (pending_any),
        .overflow    (overflow)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Step is expected on the cycle after a frame_start was sampled.
    always @(posedge vga_clk) fs_seen <= frame_start;

    always @(negedge vga_clk) begin
        if (fs_seen) begin
            if (exp_q.size() == 0)
                chk("step_unexpected_fs", {5'd0, r_step, g_step, b_step}, 8'hFF);
            else
                chk("step_rgb", {5'd0, r_step, g_step, b_step}, {5'd0, exp_q.pop_front()});
        end else if (r_step || g_step || b_step) begin
            chk("step_without_frame", {5'd0, r_step, g_step, b_step}, 8'h00);
        end
    end

    // One clock of stimulus; inputs change 1 time unit after the edge.
    task automatic cyc(input logic kv, input logic [7:0] kc, input logic fs, input logic [2:0] exp_step);
        key_valid   = kv;
        key_code    = kc;
        frame_start = fs;
        if (fs) exp_q.push_back(exp_step);
        @(posedge vga_clk);
        #1;
        key_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic key(input logic [7:0] kc);
        cyc(1'b1, kc, 1'b0, 3'b000);
    endtask

    task automatic frame(input logic [2:0] exp_step);
        cyc(1'b0, 8'h00, 1'b1, exp_step);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 3'b000);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_async_outs", {3'd0, r_step, g_step, b_step, pending_any, overflow}, 8'h00);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
    endtask

    localparam logic [2:0] S_R = 3'b100, S_G = 3'b010, S_B = 3'b001, S_0 = 3'b000;

    initial begin
        @(posedge vga_clk);
        #1;
        chk("reset_state", {3'd0, r_step, g_step, b_step, pending_any, overflow}, 8'h00);
        reset = 1'b0;
        idle(1);

        // R, G, B queued; R first, then G, then B, then nothing.
        key(8'h2D); key(8'h34); key(8'h32);
        chk("pend_after_rgb", {7'd0, pending_any}, 8'h01);
        frame(S_R); idle(1);
        frame(S_G); frame(S_B);
        chk("pend_after_drain", {7'd0, pending_any}, 8'h00);
        frame(S_0); idle(1);

        // Break sequence does not create a request; unknown code ignored.
        do_reset();
        key(8'hF0); key(8'h2D); key(8'h1C);
        chk("pend_after_break", {7'd0, pending_any}, 8'h00);
        frame(S_0);
        chk("ovf_after_break", {7'd0, overflow}, 8'h00);

        // Extended make discarded; next byte decoded from IDLE.
        key(8'hE0); key(8'h34); key(8'h32);
        frame(S_B); frame(S_0);

        // Saturation: seven fit, the eighth overflows.
        do_reset();
        for (int i = 0; i < 7; i++) key(8'h2D);
        chk("ovf_at_seven", {7'd0, overflow}, 8'h00);
        key(8'h2D);
        chk("ovf_at_eight", {7'd0, overflow}, 8'h01);
        for (int i = 0; i < 7; i++) frame(S_R);
        chk("pend_after_seven", {7'd0, pending_any}, 8'h00);
        frame(S_0);
        chk("ovf_sticky", {7'd0, overflow}, 8'h01);

        // Key at limit in the same cycle as a grant of that channel: no drop.
        do_reset();
        for (int i = 0; i < 7; i++) key(8'h2D);
        cyc(1'b1, 8'h2D, 1'b1, S_R);
        chk("ovf_inc_dec_sat", {7'd0, overflow}, 8'h00);
        key(8'h2D);
        chk("ovf_still_full", {7'd0, overflow}, 8'h01);

        // Wrap-around: pointer at G with R and B pending.
        do_reset();
        key(8'h2D); frame(S_R);
        key(8'h2D); key(8'h32);
        frame(S_B); frame(S_R); frame(S_0);
        chk("pend_after_wrap", {7'd0, pending_any}, 8'h00);

        // Simultaneous key and frame on G: granted, count stays 2.
        do_reset();
        key(8'h34); key(8'h34);
        cyc(1'b1, 8'h34, 1'b1, S_G);
        frame(S_G); frame(S_G); frame(S_0);

        // Reset mid-sequence: next byte is a fresh make code.
        do_reset();
        key(8'hE0); key(8'hF0);
        do_reset();
        key(8'h2D);
        chk("pend_after_midrst", {7'd0, pending_any}, 8'h01);
        frame(S_R); frame(S_0);

        idle(2);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/color_step_scheduler.md
COLOR_STEP_SCHEDULER -- requirements
Module: color_step_scheduler

Interface
REQ-001 Parameter MAX_PEND, default 7, saturation limit of each per-channel pending counter (1..7).
REQ-002 Parameter CODE_R, default 8'h2D, PS/2 set-2 make code requesting a red step.
REQ-003 Parameter CODE_G, default 8'h34, make code requesting a green step.
REQ-004 Parameter CODE_B, default 8'h32, make code requesting a blue step.
REQ-005 vga_clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 key_valid  in  1  one-cycle strobe, key_code is valid this cycle.
REQ-008 key_code  in  8  received keyboard byte.
REQ-009 frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-010 r_step  out  1  one-cycle step request to the red channel of the coloriser.
REQ-011 g_step  out  1  one-cycle step request to green.
REQ-012 b_step  out  1  one-cycle step request to blue.
REQ-013 pending_any  out  1  high while any pending counter is non-zero.
REQ-014 overflow  out  1  sticky, set when a request is dropped at saturation.

Function
REQ-015 The decoder SHALL be an FSM with states IDLE, EXT, BRK, advancing only on cycles with key_valid=1.
REQ-016 IDLE: 8'hE0 -> EXT; 8'hF0 -> BRK; any other byte SHALL be treated as a make code, remaining in IDLE.
REQ-017 EXT: 8'hF0 -> BRK; any other byte SHALL be discarded, returning to IDLE.
REQ-018 BRK: any byte SHALL be discarded, returning to IDLE (break codes never create requests).
REQ-019 A make code in IDLE equal to CODE_R/G/B SHALL increment the matching pending counter at the next edge; other codes SHALL be ignored.
REQ-020 Pending counters are 3 bits; an increment at MAX_PEND SHALL be dropped and SHALL set overflow.
REQ-021 On a frame_start cycle the scheduler SHALL grant at most one channel: the first non-zero counter in round-robin order starting at the pointer (order R, G, B, wrapping).
REQ-022 The granted step output SHALL be high for exactly the one cycle following frame_start (latency 1); at most one of r_step/g_step/b_step SHALL be high in any cycle.
REQ-023 The granted counter SHALL decrement by 1, and the pointer SHALL move to the channel after the granted one; with no pending requests the pointer SHALL be unchanged and no step issued.
REQ-024 An increment and a grant-decrement on the same counter in the same cycle SHALL leave it unchanged; overflow SHALL not be set in that case.
REQ-025 frame_start arriving while key_valid is high SHALL process both in the same cycle, grant decision using pre-edge counter values.
REQ-026 pending_any SHALL be combinationally derived from the registered counters.

Reset
REQ-027 Reset SHALL force FSM to IDLE, all counters to 0, pointer to R, r_step/g_step/b_step/overflow to 0, pending_any to 0, asynchronously.
REQ-028 Reset asserted mid-sequence (e.g. after F0) SHALL discard the partial sequence; the first byte after release is decoded from IDLE.

Structure
REQ-029 Package color_ctrl_pkg SHALL hold the decoder state encoding, channel index constants (R=0, G=1, B=2) and the E0/F0 prefix constants.
REQ-030 One sub-module pend_counter (3-bit saturating up/down with overflow flag) SHALL be instantiated three times.

Verification
REQ-031 Bytes 2D,34,32 then one frame_start -> r_step one cycle after frame_start; counters R=0,G=1,B=1; pointer=G.
REQ-032 Bytes F0,2D -> no counter change; next frame_start produces no step, pending_any=0.
REQ-033 Eight 2D bytes -> R counter=7, overflow=1; seven frame_starts -> seven r_step pulses, then pending_any=0.
REQ-034 Counters R=1,B=1, pointer=G; frame_start -> b_step; next frame_start -> r_step (wrap-around).
REQ-035 Counter G=2; key 34 valid in the same cycle as frame_start -> g_step issued, G stays 2.
REQ-036 Bytes E0,F0 then reset pulse, then 2D -> R counter=1 (no byte swallowed after reset).
